axilite_reg_slave: RTL and testbench
====================================

Name: axilite_reg_slave

Overview:
- Parametrised AXI4-Lite slave register file: NUM_REGS words of DATA_WIDTH bits, software read/write, contents driven out to fabric.
- Sits behind the bridge's AXI-Lite control port; supplies config registers and wr_pulse strobes to downstream logic (I2C engine, AXIS shims).
- Accepts AW and W independently in any order; applies byte strobes; returns DECERR for out-of-range addresses.

Parameters:
- DATA_WIDTH, 32, bus and register width; must be 32 or 64.
- ADDR_WIDTH, 32, AXI address width.
- NUM_REGS, 8, number of registers, 1..256.
- RESET_VALUE, 0, reset value loaded into every register (DATA_WIDTH bits).
- WSTRB_WIDTH, DATA_WIDTH/8, strobe width; not overridden.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_WIDTH  write address.
- awprot  in  3  write protection.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  WSTRB_WIDTH  byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_WIDTH  read address.
- arprot  in  3  read protection.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1  read valid.
- rready  in  1  read ready.
- reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_REGS  one-cycle pulse per register on a committed write.

Behaviour:
- Interface: one clock aclk; reset aresetn, asynchronous assert, active-low. Outputs registered; reset values: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse=0, all registers=RESET_VALUE.
- Decode: LSB=log2(WSTRB_WIDTH); index = addr[ADDR_WIDTH-1:LSB]; low LSB bits ignored. index >= NUM_REGS is out of range.
- Write FSM: W_IDLE -> (AW and/or W captured into holding regs) W_WAIT -> both held -> W_COMMIT (1 cycle: apply strobed write, pulse wr_pulse[index], bvalid=1) -> W_RESP -> bvalid&&bready -> W_IDLE.
- awready=1 only while AW holding empty and state is W_IDLE/W_WAIT; likewise wready for W. Both may handshake in the same cycle. awready/wready deassert the cycle after their handshake.
- bvalid rises 2 cycles after the later of AW/W handshakes; held, with bresp stable, until bready.
- Strobes: byte b updated iff wstrb[b]; wstrb=0 commits nothing but still pulses wr_pulse and responds OKAY.
- Out-of-range write: no register change, no wr_pulse, bresp=2'b11 (DECERR).
- Read: arready=1 when rvalid=0; on handshake rvalid=1 next cycle with rdata=reg[index], rresp=OKAY; out-of-range gives rdata=0, rresp=DECERR. rvalid/rdata held until rready; arready=0 meanwhile.
- Read and write channels independent; read accepted the cycle a write commits to the same register returns the pre-write value.
- Reset mid-transaction: all handshakes abandoned, holding regs cleared, no response issued.

Optional Feature:
- Macro AXIL_REG_PROT_CHECK_EN.
- Defined: accesses with prot[0]=0 (unprivileged) are rejected: write commits nothing and gives no wr_pulse, bresp=2'b10 (SLVERR); read returns rdata=0, rresp=SLVERR. Range check takes priority (DECERR wins).
- Undefined: awprot/arprot ignored; all in-range accesses OKAY.

Test Plan:
- Reset, then read all regs with RESET_VALUE=32'hA5A5_0000 -> each rdata=32'hA5A5_0000, rresp=0; all outputs 0 during reset.
- AW 0x04 at cycle 0, W 32'h1234_5678 strobe 4'hF at cycle 3 -> bvalid cycle 5; reg_q[63:32]=32'h1234_5678; wr_pulse=8'h02 for exactly one cycle.
- Write 32'hFFFF_FFFF to reg 2 then 32'h0000_00AB with wstrb=4'b0001 -> read returns 32'hFFFF_FFAB.
- Write/read address 0x20 with NUM_REGS=8 -> bresp=2'b11, rresp=2'b11, rdata=0, no wr_pulse, reg_q unchanged.
- Hold bready=0 and rready=0 for 10 cycles -> bvalid/rvalid, bresp/rdata stable; awready/wready/arready stay 0; new AW not accepted.
- With AXIL_REG_PROT_CHECK_EN, write with awprot=3'b000 -> bresp=2'b10, register unchanged; awprot=3'b001 -> OKAY, written.

Source files
------------

// File: rtl/axilite_reg_slave.sv
// axilite_reg_slave: AXI4-Lite slave register file.
// NUM_REGS words of DATA_WIDTH bits, readable and writable from the bus and
// driven out flat on reg_q. Each committed write pulses wr_pulse[index] for
// one cycle so downstream logic can react to software writes.
// AW and W are accepted independently and in either order. Byte strobes are
// honoured, and addresses past the last register answer DECERR.
// Optional build macro AXIL_REG_PROT_CHECK_EN: when defined, unprivileged
// accesses (prot[0] == 0) are refused with SLVERR. Out-of-range accesses
// still report DECERR first.
module axilite_reg_slave #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    WSTRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    // write data channel
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [WSTRB_WIDTH-1:0]         wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    // write response channel
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,
    // read data channel
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    // fabric side
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    // Byte-offset bits below the word index; they are ignored by the decode.
    localparam int LSB   = $clog2(WSTRB_WIDTH);
    localparam int IDX_W = ADDR_WIDTH - LSB;
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // Range compare is done at a width that can hold NUM_REGS (up to 256).
    localparam int CMP_W = (IDX_W > 9) ? IDX_W : 9;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_COMMIT,
        W_RESP
    } w_state_t;

    // Register storage and write-side holding registers
    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];
    w_state_t               w_state;
    logic                   aw_held;
    logic                   w_held;
    logic [IDX_W-1:0]       aw_idx_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [WSTRB_WIDTH-1:0] wstrb_q;

    // Handshake and decode helpers
    logic                   aw_hs;
    logic                   w_hs;
    logic                   ar_hs;
    logic                   aw_full;
    logic                   w_full;
    logic                   wr_in_range;
    logic                   wr_priv;
    logic                   commit;
    logic [1:0]             wr_resp;
    logic [IDX_W-1:0]       ar_idx;
    logic                   rd_in_range;
    logic                   rd_priv;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return CMP_W'(idx) < CMP_W'(NUM_REGS);
    endfunction

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    // Holding occupancy as it will be after the current edge.
    assign aw_full = aw_held || aw_hs;
    assign w_full  = w_held || w_hs;

    assign ar_idx      = araddr[ADDR_WIDTH-1:LSB];
    assign rd_in_range = in_range(ar_idx);
    assign wr_in_range = in_range(aw_idx_q);

`ifdef AXIL_REG_PROT_CHECK_EN
    logic aw_priv_q;
    logic unused_bits;
    assign unused_bits = ^{awprot[2:1], arprot[2:1], awaddr[LSB-1:0], araddr[LSB-1:0]};
    assign wr_priv     = aw_priv_q;
    assign rd_priv     = arprot[0];
`else
    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, awaddr[LSB-1:0], araddr[LSB-1:0]};
    assign wr_priv     = 1'b1;
    assign rd_priv     = 1'b1;
`endif

    // A held write only touches the register file when it is in range and allowed.
    assign commit = (w_state == W_COMMIT) && wr_in_range && wr_priv;

    // Response code for the held write; the range error outranks the privilege error.
    always_comb begin
        // NOTE: default assignment first, so no path through the block leaves
        // wr_resp unassigned and no latch is inferred.
        wr_resp = RESP_OKAY;
        if (!wr_in_range) begin
            wr_resp = RESP_DECERR;
        end else if (!wr_priv) begin
            wr_resp = RESP_SLVERR;
        end
    end

    // Write channel FSM: capture AW/W independently, commit once both are held, then respond.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            wr_pulse  <= '0;
`ifdef AXIL_REG_PROT_CHECK_EN
            aw_priv_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand side
            // reads the pre-edge value regardless of statement order.
            wr_pulse <= '0;
            case (w_state)
                W_IDLE, W_WAIT: begin
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        aw_idx_q  <= awaddr[ADDR_WIDTH-1:LSB];
`ifdef AXIL_REG_PROT_CHECK_EN
                        aw_priv_q <= awprot[0];
`endif
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                    end
                    // Each ready drops the cycle after its own handshake.
                    awready <= !aw_full;
                    wready  <= !w_full;
                    if (aw_full && w_full) begin
                        w_state <= W_COMMIT;
                    end else if (aw_full || w_full) begin
                        w_state <= W_WAIT;
                    end
                end
                W_COMMIT: begin
                    if (commit) begin
                        wr_pulse[aw_idx_q[SEL_W-1:0]] <= 1'b1;
                    end
                    bvalid  <= 1'b1;
                    bresp   <= wr_resp;
                    w_state <= W_RESP;
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Register file: strobed byte update on commit, loaded with RESET_VALUE in reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: this array is reset on purpose; reg_q feeds live config
            // straight into fabric, so it must hold a defined value from reset.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (commit) begin
            for (int b = 0; b < WSTRB_WIDTH; b++) begin
                if (wstrb_q[b]) begin
                    regs[aw_idx_q[SEL_W-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    // Read channel: one outstanding read; data sampled at the AR handshake and held until rready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid  <= 1'b1;
            arready <= 1'b0;
            if (!rd_in_range) begin
                rdata <= '0;
                rresp <= RESP_DECERR;
            end else if (!rd_priv) begin
                rdata <= '0;
                rresp <= RESP_SLVERR;
            end else begin
                rdata <= regs[ar_idx[SEL_W-1:0]];
                rresp <= RESP_OKAY;
            end
        end else if (rvalid) begin
            if (rready) begin
                rvalid  <= 1'b0;
                arready <= 1'b1;
            end
        end else begin
            arready <= 1'b1;
        end
    end

    // Flatten the register file onto the fabric-side bus.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
    end

endmodule

// File: tb/tb_axilite_reg_slave.sv
// tb_axilite_reg_slave: directed bench for axilite_reg_slave (8 x 32-bit,
// RESET_VALUE = 32'hA5A5_0000). A word-level model of the register file
// predicts reg_q and wr_pulse on every cycle; the transaction tasks check
// handshakes, latencies and responses. A few literal expectations pin the model.
// Build with AXIL_REG_PROT_CHECK_EN defined to exercise the privilege check.
module tb_axilite_reg_slave;

    localparam logic [31:0] RV = 32'hA5A5_0000;

    logic         aclk;
    logic         aresetn;
    logic [31:0]  awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] reg_q;
    logic [7:0]   wr_pulse;

    int total = 0;
    int bad   = 0;

    // Model state: register contents and the wr_pulse expected in the current cycle.
    logic [31:0] exp_regs [8];
    logic [7:0]  exp_pulse;

    axilite_reg_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .NUM_REGS   (8),
        .RESET_VALUE(RV)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .reg_q   (reg_q),
        .wr_pulse(wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 8; i++) exp_regs[i] = RV;
        exp_pulse = '0;
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = exp_regs[i];
        return f;
    endfunction

    function automatic bit model_allowed(input logic [2:0] prot);
`ifdef AXIL_REG_PROT_CHECK_EN
        return prot[0];
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [1:0] model_wresp(input logic [31:0] addr, input logic [2:0] prot);
        if ((addr >> 2) >= 8) return 2'b11;
        if (!model_allowed(prot)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic void model_apply(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb, input logic [2:0] prot);
        int idx;
        idx = int'(addr >> 2);
        exp_pulse = '0;
        if (idx < 8 && model_allowed(prot)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) exp_regs[idx][b*8 +: 8] = data[b*8 +: 8];
            exp_pulse[idx] = 1'b1;
        end
    endfunction

    function automatic void model_read(input logic [31:0] addr, input logic [2:0] prot,
                                       output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = int'(addr >> 2);
        if (idx >= 8) begin
            d = '0; r = 2'b11;
        end else if (!model_allowed(prot)) begin
            d = '0; r = 2'b10;
        end else begin
            d = exp_regs[idx]; r = 2'b00;
        end
    endfunction

    // Per-cycle comparison of fabric-side outputs against the model.
    always @(negedge aclk) begin
        if (!aresetn) begin
            check("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, wr_pulse}, '0);
            check("reset_regs", reg_q, model_flat());
        end else begin
            check("reg_q", reg_q, model_flat());
            check("wr_pulse", wr_pulse, exp_pulse);
        end
    end

    // ---------------- transactions (enter and leave at posedge + 1) ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input int aw_dly, input int w_dly,
                            input int hold, input bit poke_aw,
                            output int lat, output logic [1:0] got_resp);
        int n;
        bit aw_done, w_done, aw_now, w_now, applied;
        logic [1:0] eresp;
        aw_done = 0; w_done = 0; n = 0; lat = -1; applied = 0; got_resp = 'x;
        while (!(aw_done && w_done) && n < 40) begin
            if (!aw_done && n >= aw_dly) begin awaddr = addr; awprot = prot; awvalid = 1'b1; end
            if (!w_done && n >= w_dly) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
            @(negedge aclk);
            if (aw_done) check("awready_low_after_hs", awready, 0);
            if (w_done) check("wready_low_after_hs", wready, 0);
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_now) begin aw_done = 1; awvalid = 1'b0; end
            if (w_now) begin w_done = 1; wvalid = 1'b0; end
            n++;
        end
        check("write_handshakes", {aw_done, w_done}, 2'b11);
        // Later handshake was at cycle n-1; the response is due at cycle n+1.
        eresp = model_wresp(addr, prot);
        for (int k = 0; k < 8 && lat < 0; k++) begin
            if (k == 1) begin model_apply(addr, data, strb, prot); applied = 1; end
            @(negedge aclk);
            if (bvalid) lat = n + k;
            else begin @(posedge aclk); #1; end
        end
        if (!applied) model_apply(addr, data, strb, prot);
        check("bvalid_latency", lat, n + 1);
        got_resp = bresp;
        check("bresp", bresp, eresp);
        for (int h = 0; h < hold; h++) begin
            @(posedge aclk); #1;
            exp_pulse = '0;
            if (poke_aw) begin awaddr = 32'h0; awprot = prot; awvalid = 1'b1; end
            @(negedge aclk);
            check("bvalid_held", bvalid, 1);
            check("bresp_stable", bresp, eresp);
            check("aw_w_ready_low", {awready, wready}, 2'b00);
        end
        @(posedge aclk); #1;
        exp_pulse = '0; awvalid = 1'b0; bready = 1'b1;
        @(negedge aclk);
        check("bvalid_at_accept", bvalid, 1);
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk);
        check("bvalid_cleared", bvalid, 0);
        check("ready_after_resp", {awready, wready}, 2'b11);
        @(posedge aclk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int dly,
                           input int hold, output logic [31:0] got, output logic [1:0] got_resp);
        bit hs;
        logic [31:0] ed;
        logic [1:0] er;
        hs = 0; ed = '0; er = '0;
        repeat (dly) begin @(posedge aclk); #1; end
        araddr = addr; arprot = prot; arvalid = 1'b1;
        for (int k = 0; k < 20 && !hs; k++) begin
            @(negedge aclk);
            if (arready) begin hs = 1; model_read(addr, prot, ed, er); end
            @(posedge aclk); #1;
        end
        arvalid = 1'b0;
        check("ar_handshake", hs, 1);
        @(negedge aclk);
        got = rdata; got_resp = rresp;
        check("rvalid", rvalid, 1);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        check("arready_busy", arready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge aclk); #1;
            @(negedge aclk);
            check("rvalid_held", rvalid, 1);
            check("rdata_stable", {rresp, rdata}, {er, ed});
            check("arready_held_low", arready, 0);
        end
        @(posedge aclk); #1;
        rready = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1;
        rready = 1'b0;
        @(negedge aclk);
        check("rvalid_cleared", rvalid, 0);
        check("arready_back", arready, 1);
        @(posedge aclk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          lat, lat2;
        logic [1:0]  r, rr;
        logic [31:0] got, got2;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        model_reset();
        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        // Every register reads back its reset value.
        for (int i = 0; i < 8; i++) begin
            do_read(32'(i * 4), 3'b001, 0, 0, got, rr);
            check("pin_reset_read", {rr, got}, {2'b00, 32'hA5A5_0000});
        end

        // AW at cycle 0, W at cycle 3: response at cycle 5.
        do_write(32'h04, 32'h1234_5678, 4'hF, 3'b001, 0, 3, 0, 0, lat, r);
        check("pin_bvalid_cycle5", lat, 5);
        check("pin_reg1", reg_q[63:32], 32'h1234_5678);

        // Byte strobes; second write presents W before AW.
        do_write(32'h08, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, 0, 0, 0, lat, r);
        do_write(32'h08, 32'h0000_00AB, 4'b0001, 3'b001, 2, 0, 0, 0, lat, r);
        do_read(32'h08, 3'b001, 0, 0, got, rr);
        check("pin_strobe_merge", got, 32'hFFFF_FFAB);

        // Zero strobe: pulses and answers OKAY but changes nothing.
        do_write(32'h04, 32'hDEAD_BEEF, 4'h0, 3'b001, 0, 0, 0, 0, lat, r);
        check("pin_zero_strobe", {r, reg_q[63:32]}, {2'b00, 32'h1234_5678});

        // Out-of-range address.
        do_write(32'h20, 32'h5555_5555, 4'hF, 3'b001, 1, 0, 0, 0, lat, r);
        check("pin_oor_bresp", r, 2'b11);
        do_read(32'h20, 3'b001, 0, 0, got, rr);
        check("pin_oor_read", {rr, got}, {2'b11, 32'h0});

        // Back-pressure on both response channels, with a new AW offered meanwhile.
        do_write(32'h0C, 32'h0BAD_F00D, 4'hF, 3'b001, 0, 0, 10, 1, lat, r);
        do_read(32'h0C, 3'b001, 0, 10, got, rr);
        check("pin_hold_read", got, 32'h0BAD_F00D);

        // Read accepted on the commit edge of a write to the same register.
        fork
            do_write(32'h0C, 32'h7777_7777, 4'hF, 3'b001, 0, 0, 0, 0, lat2, r);
            do_read(32'h0C, 3'b001, 1, 0, got, rr);
        join
        check("pin_read_pre_write", got, 32'h0BAD_F00D);
        do_read(32'h0C, 3'b001, 0, 0, got2, rr);
        check("pin_read_post_write", got2, 32'h7777_7777);

        // Unprivileged accesses, then a privileged write.
        do_write(32'h10, 32'hCAFE_0001, 4'hF, 3'b000, 0, 0, 0, 0, lat, r);
        do_read(32'h10, 3'b000, 0, 0, got, rr);
`ifdef AXIL_REG_PROT_CHECK_EN
        check("pin_prot_wr", {r, reg_q[159:128]}, {2'b10, 32'hA5A5_0000});
        check("pin_prot_rd", {rr, got}, {2'b10, 32'h0});
`else
        check("pin_prot_wr", {r, reg_q[159:128]}, {2'b00, 32'hCAFE_0001});
        check("pin_prot_rd", {rr, got}, {2'b00, 32'hCAFE_0001});
`endif
        do_write(32'h10, 32'hCAFE_0002, 4'hF, 3'b001, 0, 0, 0, 0, lat, r);
        check("pin_priv_wr", {r, reg_q[159:128]}, {2'b00, 32'hCAFE_0002});

        // Reset with an AW to reg 5 captured but no W: the AW must be dropped.
        awaddr = 32'h14; awprot = 3'b001; awvalid = 1'b1;
        @(negedge aclk);
        check("aw_ready_pre_reset", awready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        aresetn = 1'b0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("no_resp_after_reset", bvalid, 0);
        @(posedge aclk); #1;
        do_write(32'h18, 32'h6666_6666, 4'hF, 3'b001, 4, 0, 0, 0, lat, r);
        check("pin_post_reset_regs", reg_q[223:160], {32'h6666_6666, 32'hA5A5_0000});

        for (int i = 0; i < 8; i++) do_read(32'(i * 4), 3'b001, 0, 0, got, rr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
